param_barrel_shifter_pipe: RTL and testbench
============================================

# param_barrel_shifter_pipe

Pipelined, parametrised barrel shifter for W = 2**N bit data. It supports four shift modes (logical left, logical right, arithmetic right, rotate left) and carries a valid/ready handshake on both sides. It replaces the single-cycle combinational left shifter in datapaths that need full-throughput shifting at higher clock rates, one log-stage per pipeline register.

## Interface
Parameters:
- N, default 3, log2 of data width; W = 2**N, shift amount is N bits.

Ports:
- clk  input  1  rising-edge clock; the block uses one clock only.
- reset  input  1  asynchronous, active-high; clears all pipeline state.
- in_valid  input  1  input word present.
- in_ready  output  1  block accepts input this cycle.
- a  input  W  data to shift.
- amt  input  N  shift amount, 0..W-1.
- mode  input  2  shift_mode_t: 00 LSL, 01 LSR, 10 ASR, 11 ROL.
- out_valid  output  1  y holds a result.
- out_ready  input  1  downstream accepts y.
- y  output  W  shifted result.

## Operation
- Input transfer occurs when in_valid && in_ready at a rising edge. Output transfer occurs when out_valid && out_ready.
- Stage k (k = 0..N-1) applies a shift of 2**k when amt bit k is set, and passes data through unchanged otherwise. Each stage registers data, its valid bit, mode and the remaining amt bits.
- Mode rules per stage, with shift s = 2**k:
  - LSL: data << s, zero fill.
  - LSR: data >> s, zero fill.
  - ASR: data >>> s, fill with sign bit of the stage input. The sign bit of the original a is preserved through all stages.
  - ROL: {data[W-1-s:0], data[W-1:W-s]}.
- Whole-pipe stall: advance = !out_valid || out_ready.
  - in_ready = advance. The output is combinational from out_valid/out_ready; there is no skid buffer.
  - When advance = 0, every stage register holds.
  - When advance = 1, every stage shifts forward one position and stage 0 captures the input. If no input transfer occurs, stage 0 captures a bubble (valid = 0).
- Bubbles are not collapsed. Results leave in acceptance order, and none are dropped or duplicated.
- y is the data register of stage N-1. out_valid is the valid register of stage N-1.
- amt = 0 returns a unchanged in every mode.
- Only valid bits control the handshake. The data of bubbles is don't-care, but it must never raise out_valid.

## Timing
- Reset (asynchronous assert, synchronous use after deassert) drives:
  - all stage valid bits = 0, out_valid = 0;
  - y = 0 and all stage data = 0;
  - in_ready = 1, since out_valid = 0.
- Reset mid-operation discards every in-flight word. The first valid output after reset comes from the first transfer after reset.
- Latency: a word transferred at edge t appears on y with out_valid = 1 after edge t+N-1, provided no stall occurs. For N = 3: accept at edge 0, result visible after edge 2. Each stall cycle adds exactly one cycle.
- Throughput: one word per cycle while out_ready = 1.
- A simultaneous output transfer and input transfer in the same cycle is legal and required for full throughput.
- While out_valid = 1 and out_ready = 0: in_ready = 0, and y and out_valid remain stable until the transfer.

## Structure
- Package shifter_pkg holds:
  - typedef enum logic [1:0] shift_mode_t {SH_LSL, SH_LSR, SH_ASR, SH_ROL};
  - a function computing the one-stage shift (data, s, mode, do_shift), shared by RTL and the bench reference model.
- Sub-module shifter_stage, parametrised by N and STAGE. It is one registered log-stage with data, amt, mode, valid and a shared enable. The top level instantiates it N times in a generate loop and adds the handshake logic.
- The implementation is 120–250 lines total.

## Test plan
All scenarios use N = 3 (W = 8).
- LSL, a = 8'b1001_0110, amt = 3: y = 8'b1011_0000, out_valid after edge t+2.
- LSR / ASR / ROL with the same a and amt = 3:
  - LSR: y = 8'b0001_0010.
  - ASR: y = 8'b1111_0010.
  - ROL: y = 8'b1011_0100.
- Edge amounts:
  - amt = 0, every mode: y = a.
  - ASR with a = 8'h80, amt = 7: y = 8'hFF.
  - ROL with a = 8'h81, amt = 7: y = 8'hC0.
- Back-to-back streaming of 8 words with out_ready = 1: eight consecutive out_valid cycles, in order, each matching the package reference function.
- Backpressure: stream words, hold out_ready = 0 for 4 cycles.
  - in_ready = 0 throughout, y stable.
  - After release, no loss or duplication, order preserved.
- Reset asserted with 2 words in flight: out_valid = 0 and y = 0 immediately, with no clock edge needed. The in-flight words never appear. A new word after reset appears after the usual 3 edges.

Source files
------------

// File: rtl/shifter_pkg.sv
// Shared types and the one-stage shift function used by the pipelined barrel shifter
// and by its reference model.
package shifter_pkg;

  typedef enum logic [1:0] {SH_LSL, SH_LSR, SH_ASR, SH_ROL} shift_mode_t;

  localparam int MAX_LOG = 6;
  localparam int MAX_W   = 1 << MAX_LOG;

  typedef logic [MAX_LOG-1:0] idx_t;
  typedef logic [MAX_W-1:0]   word_t;

  // Shift the low w bits of data by s in the given mode; bits at and above w stay zero.
  // w and s are elaboration constants at every RTL call site, so the loop unrolls to wiring.
  function automatic word_t shift_step(input word_t       data,
                                       input int          w,
                                       input int          s,
                                       input shift_mode_t mode,
                                       input logic        do_shift);
    word_t r;
    int    src;
    r   = '0;
    src = 0;
    if (!do_shift) begin
      r = data;
    end else begin
      for (int i = 0; i < MAX_W; i++) begin
        if (i < w) begin
          case (mode)
            SH_LSL: begin
              src = i - s;
              r[idx_t'(i)] = (src >= 0) ? data[idx_t'(src)] : 1'b0;
            end
            SH_LSR: begin
              src = i + s;
              r[idx_t'(i)] = (src < w) ? data[idx_t'(src)] : 1'b0;
            end
            SH_ASR: begin
              src = i + s;
              r[idx_t'(i)] = (src < w) ? data[idx_t'(src)] : data[idx_t'(w - 1)];
            end
            default: begin
              src = (i - s + w) % w;
              r[idx_t'(i)] = data[idx_t'(src)];
            end
          endcase
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/shifter_stage.sv
// One registered log-stage: conditionally shifts by 2**STAGE and forwards
// valid, mode and amount under a pipe-wide enable.
module shifter_stage
  import shifter_pkg::*;
#(
  parameter int N     = 3,
  parameter int STAGE = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en_i,
  input  logic              vld_i,
  input  logic [(1<<N)-1:0] data_i,
  input  logic [N-1:0]      amt_i,
  input  shift_mode_t       mode_i,
  output logic              vld_o,
  output logic [(1<<N)-1:0] data_o,
  output logic [N-1:0]      amt_o,
  output shift_mode_t       mode_o
);
  localparam int W = 1 << N;

  logic [W-1:0] data_d, data_q;
  logic [N-1:0] amt_q;
  logic         vld_q;
  shift_mode_t  mode_q;
  word_t        ext_w;

  always_comb begin
    ext_w        = '0;
    ext_w[W-1:0] = data_i;
    data_d       = W'(shift_step(ext_w, W, 1 << STAGE, mode_i, amt_i[STAGE]));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_q  <= 1'b0;
      data_q <= '0;
      amt_q  <= '0;
      mode_q <= SH_LSL;
    end else if (en_i) begin
      vld_q  <= vld_i;
      data_q <= data_d;
      amt_q  <= amt_i;
      mode_q <= mode_i;
    end
  end

  assign vld_o  = vld_q;
  assign data_o = data_q;
  assign amt_o  = amt_q;
  assign mode_o = mode_q;

endmodule

// File: rtl/param_barrel_shifter_pipe.sv
// Pipelined W=2**N barrel shifter (LSL/LSR/ASR/ROL), one log-stage per register,
// with a whole-pipe stall driven by the output handshake.
module param_barrel_shifter_pipe
  import shifter_pkg::*;
#(
  parameter int N = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [(1<<N)-1:0] a,
  input  logic [N-1:0]      amt,
  input  shift_mode_t       mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [(1<<N)-1:0] y
);
  localparam int W = 1 << N;

  logic              advance;
  logic [N:0]        vld_pipe;
  logic [N:0][W-1:0] data_pipe;
  logic [N:0][N-1:0] amt_pipe;
  shift_mode_t       mode_pipe [N+1];
  logic              unused_tail;

  // No skid buffer: the whole pipe freezes while a result waits downstream.
  assign advance  = !vld_pipe[N] || out_ready;
  assign in_ready = advance;

  assign vld_pipe[0]  = in_valid;
  assign data_pipe[0] = a;
  assign amt_pipe[0]  = amt;
  assign mode_pipe[0] = mode;

  for (genvar k = 0; k < N; k++) begin : g_stage
    shifter_stage #(.N(N), .STAGE(k)) u_stage (
      .clk    (clk),
      .reset  (reset),
      .en_i   (advance),
      .vld_i  (vld_pipe[k]),
      .data_i (data_pipe[k]),
      .amt_i  (amt_pipe[k]),
      .mode_i (mode_pipe[k]),
      .vld_o  (vld_pipe[k+1]),
      .data_o (data_pipe[k+1]),
      .amt_o  (amt_pipe[k+1]),
      .mode_o (mode_pipe[k+1])
    );
  end

  assign out_valid = vld_pipe[N];
  assign y         = data_pipe[N];

  // Last stage's control copy has no consumer.
  assign unused_tail = ^{amt_pipe[N], mode_pipe[N]};

endmodule

// File: tb/tb_param_barrel_shifter_pipe.sv
// Directed bench for param_barrel_shifter_pipe (N=3): scoreboard model plus literal vectors.
module tb_param_barrel_shifter_pipe;
  import shifter_pkg::*;

  localparam int N = 3;
  localparam int W = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] a, y;
  logic [N-1:0] amt;
  shift_mode_t mode;

  int checks = 0;
  int fails  = 0;
  int ov_run = 0;
  int ov_max = 0;

  typedef struct {
    logic [W-1:0] exp;
    int           adv;
  } ent_t;
  ent_t q[$];

  param_barrel_shifter_pipe #(.N(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .amt       (amt),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Plain whole-amount arithmetic model.
  function automatic logic [W-1:0] model(input logic [W-1:0] d, input int s, input shift_mode_t m);
    logic [W-1:0] r;
    case (m)
      SH_LSL:  r = d << s;
      SH_LSR:  r = d >> s;
      SH_ASR:  r = W'($signed(d) >>> s);
      default: r = (s == 0) ? d : ((d << s) | (d >> (W - s)));
    endcase
    return r;
  endfunction

  function automatic logic [W-1:0] pkg_ref(input logic [W-1:0] d, input logic [N-1:0] s, input shift_mode_t m);
    word_t w;
    w = '0;
    w[W-1:0] = d;
    for (int k = 0; k < N; k++) w = shift_step(w, W, 1 << k, m, s[k]);
    return w[W-1:0];
  endfunction

  // Scoreboard: each accepted word counts pipe advances; it must be on y after N of them.
  always @(negedge clk) begin
    logic exp_vld, adv;
    if (reset) begin
      q.delete();
      ov_run = 0;
    end else begin
      exp_vld = (q.size() > 0) && (q[0].adv >= N);
      adv     = !exp_vld || out_ready;
      chk("out_valid", {7'd0, out_valid}, {7'd0, exp_vld});
      chk("in_ready", {7'd0, in_ready}, {7'd0, adv});
      if (exp_vld) chk("y", y, q[0].exp);
      if (out_valid) begin
        ov_run++;
        if (ov_run > ov_max) ov_max = ov_run;
      end else ov_run = 0;
      if (exp_vld && out_ready) void'(q.pop_front());
      if (adv) begin
        foreach (q[i]) q[i].adv++;
        if (in_valid) begin
          ent_t e;
          e.exp = model(a, int'(amt), mode);
          e.adv = 1;
          chk("pkgfn", pkg_ref(a, amt, mode), e.exp);
          q.push_back(e);
        end
      end
    end
  end

  // Called at posedge+1; single word with a literal expectation after N-1 further edges.
  task automatic send_one(input string name, input logic [W-1:0] d, input logic [N-1:0] s,
                          input shift_mode_t m, input logic [W-1:0] exp);
    in_valid = 1'b1; a = d; amt = s; mode = m;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (N - 1) @(posedge clk);
    @(negedge clk);
    chk({name, "_vld"}, {7'd0, out_valid}, 8'd1);
    chk(name, y, exp);
    @(posedge clk); #1;
  endtask

  task automatic stream(input int n, input logic [W-1:0] base);
    int   i = 0;
    int   guard = 0;
    logic took;
    while (i < n && guard < 200) begin
      in_valid = 1'b1;
      a    = W'(base + W'(i * 37));
      amt  = N'(i);
      mode = shift_mode_t'(2'(i));
      @(negedge clk);
      took = in_ready;
      @(posedge clk); #1;
      if (took) i++;
      guard++;
    end
    in_valid = 1'b0;
    chk("stream_sent", W'(i), W'(n));
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; a = '0; amt = '0; mode = SH_LSL; out_ready = 1'b1;
    #12;
    chk("rst_out_valid", {7'd0, out_valid}, 8'd0);
    chk("rst_y", y, 8'h00);
    chk("rst_in_ready", {7'd0, in_ready}, 8'd1);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;

    send_one("lsl3", 8'b1001_0110, 3'd3, SH_LSL, 8'b1011_0000);
    send_one("lsr3", 8'b1001_0110, 3'd3, SH_LSR, 8'b0001_0010);
    send_one("asr3", 8'b1001_0110, 3'd3, SH_ASR, 8'b1111_0010);
    send_one("rol3", 8'b1001_0110, 3'd3, SH_ROL, 8'b1011_0100);
    for (int m = 0; m < 4; m++) send_one("amt0", 8'hA5, 3'd0, shift_mode_t'(2'(m)), 8'hA5);
    send_one("asr7", 8'h80, 3'd7, SH_ASR, 8'hFF);
    send_one("rol7", 8'h81, 3'd7, SH_ROL, 8'hC0);

    // Back-to-back streaming
    ov_max = 0;
    stream(8, 8'h3C);
    repeat (N + 2) @(posedge clk); #1;
    chk("stream_run", W'(ov_max), 8'd8);

    // Backpressure: hold out_ready low for 4 cycles mid-stream
    fork
      stream(10, 8'h5A);
      begin
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (4) begin
          @(negedge clk);
          chk("bp_in_ready", {7'd0, in_ready}, 8'd0);
          @(posedge clk);
        end
        #1 out_ready = 1'b1;
      end
    join
    for (int g = 0; g < 50 && q.size() != 0; g++) @(posedge clk);
    #1;
    chk("drain", W'(q.size()), 8'd0);

    // Reset with words in flight
    @(posedge clk); #1;
    in_valid = 1'b1; a = 8'hF0; amt = 3'd0; mode = SH_LSL;
    @(posedge clk); #1;
    a = 8'h11; amt = 3'd1;
    @(posedge clk); #1;
    a = 8'h22;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("pre_rst_y", y, 8'hF0);
    #1 reset = 1'b1;
    #1;
    chk("mid_rst_out_valid", {7'd0, out_valid}, 8'd0);
    chk("mid_rst_y", y, 8'h00);
    chk("mid_rst_in_ready", {7'd0, in_ready}, 8'd1);
    @(posedge clk);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    send_one("post_rst", 8'h3C, 3'd2, SH_LSL, 8'hF0);
    repeat (6) @(posedge clk); #1;
    chk("post_rst_drain", W'(q.size()), 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
